mac_scheduler: RTL and testbench

- Shares one multi-cycle signed multiplier between two requesters and accumulates each requester's products into its own accumulator.
- Arbitrates round-robin, launches the multiplier with a one-cycle start pulse, waits for its done flag, updates the owning accumulator, then returns the result over a valid/ready response channel.
- Sits between requester logic and the multiplier datapath. It owns all multiplier sequencing.

---
 rtl/mac_scheduler.sv | 140 ++++++++++++++
 tb/tb_mac_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_scheduler.sv
// Round-robin scheduler sharing one multi-cycle signed multiplier between two
// requesters, with a per-requester accumulator and a valid/ready response.
module mac_scheduler #(
  parameter int WIDTH   = 8,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_w0,
  input  logic [WIDTH-1:0]   req_x0,
  input  logic [WIDTH-1:0]   req_w1,
  input  logic [WIDTH-1:0]   req_x1,
  input  logic [1:0]         req_clr,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_w,
  output logic [WIDTH-1:0]   mul_x,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [ACC_W-1:0]   resp_acc,
  output logic               resp_err,
  output logic [1:0]         acc_ovf
);

  localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_RESP
  } state_t;

  state_t               r_state;
  logic                 r_pri;
  logic                 r_id;
  logic                 r_clr;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [ACC_W-1:0]     r_acc [2];

  logic                 w_gnt_id;
  logic                 w_hs;
  logic [ACC_W-1:0]     w_base;
  logic [ACC_W:0]       w_sum;
  logic                 w_ovf;

  // r_pri holds the requester favoured on a tie (the one not served last).
  always_comb begin
    w_gnt_id  = (req_valid == 2'b11) ? r_pri : req_valid[1];
    req_ready = 2'b00;
    if (r_state == S_IDLE && (|req_valid) && !rst)
      req_ready = w_gnt_id ? 2'b10 : 2'b01;
    w_hs = |(req_valid & req_ready);
  end

  always_comb begin
    w_base = r_clr ? '0 : r_acc[r_id];
    w_sum  = {w_base[ACC_W-1], w_base}
           + {{(ACC_W+1-2*WIDTH){r_prod[2*WIDTH-1]}}, r_prod};
    w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pri      <= 1'b0;
      r_id       <= 1'b0;
      r_clr      <= 1'b0;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_acc[0]   <= '0;
      r_acc[1]   <= '0;
      mul_start  <= 1'b0;
      mul_w      <= '0;
      mul_x      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_acc   <= '0;
      resp_err   <= 1'b0;
      acc_ovf    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_id      <= w_gnt_id;
            mul_w     <= w_gnt_id ? req_w1 : req_w0;
            mul_x     <= w_gnt_id ? req_x1 : req_x0;
            r_clr     <= req_clr[w_gnt_id];
            mul_start <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            r_prod  <= mul_p;
            r_state <= S_ACCUM;
          end else if (r_cnt == CW'(TIMEOUT-1)) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_id    <= r_id;
            resp_acc   <= r_acc[r_id];
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          r_acc[r_id]   <= w_sum[ACC_W-1:0];
          acc_ovf[r_id] <= (r_clr ? 1'b0 : acc_ovf[r_id]) | w_ovf;
          resp_valid    <= 1'b1;
          resp_err      <= 1'b0;
          resp_id       <= r_id;
          resp_acc      <= w_sum[ACC_W-1:0];
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_pri      <= ~resp_id;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_scheduler.sv
// Scoreboard bench for mac_scheduler: randomized requests, behavioural
// multiplier, arithmetic accumulator model, decoupled response monitor.
module tb_mac_scheduler;

  localparam int WIDTH   = 8;
  localparam int ACC_W   = 16;
  localparam int TIMEOUT = 16;

  logic               clk;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_w0, req_x0, req_w1, req_x1;
  logic [1:0]         req_clr;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_w, mul_x;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [ACC_W-1:0]   resp_acc;
  logic               resp_err;
  logic [1:0]         acc_ovf;

  mac_scheduler #(.WIDTH(WIDTH), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_w0(req_w0), .req_x0(req_x0), .req_w1(req_w1), .req_x1(req_x1),
    .req_clr(req_clr),
    .mul_start(mul_start), .mul_w(mul_w), .mul_x(mul_x),
    .mul_done(mul_done), .mul_p(mul_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_acc(resp_acc), .resp_err(resp_err), .acc_ovf(acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    longint     acc;
    bit         err;
    logic [1:0] ovf;
    longint     hs;
    int         lat;
    int         stall;
  } exp_t;

  exp_t   sb[$];
  int     lat_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_pushed = 0;
  int     n_done   = 0;

  // Reference state: accumulators as plain signed integers.
  longint     m_acc [2];
  logic [1:0] m_ovf;
  int         m_pri;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint m;
    longint r;
    m = longint'(1) << ACC_W;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint all_outputs();
    return longint'({req_ready, mul_start, mul_w, mul_x, resp_valid,
                     resp_id, resp_acc, resp_err, acc_ovf});
  endfunction

  // lat = cycles from mul_start to mul_done; 0 means the multiplier never answers.
  task automatic do_op(input logic [1:0] v, input int w0, input int x0,
                       input int w1, input int x1, input logic [1:0] clr,
                       input int lat, input int stall, input bit expect_resp);
    int     g;
    int     t;
    int     w;
    int     x;
    longint base;
    longint exact;
    exp_t   e;
    @(negedge clk);
    req_valid = v;
    req_w0 = w0[WIDTH-1:0];
    req_x0 = x0[WIDTH-1:0];
    req_w1 = w1[WIDTH-1:0];
    req_x1 = x1[WIDTH-1:0];
    req_clr = clr;
    #1;
    t = 0;
    while (req_ready == 2'b00 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (req_ready == 2'b00) begin
      chk("grant_timeout", 0, 1);
      req_valid = 2'b00;
      return;
    end
    g = (v == 2'b11) ? m_pri : ((v == 2'b10) ? 1 : 0);
    chk("req_ready_grant", longint'(req_ready), (g == 1) ? 2 : 1);
    w = (g == 1) ? w1 : w0;
    x = (g == 1) ? x1 : x0;
    lat_q.push_back(lat);
    e.id = g;
    e.hs = cyc;
    e.stall = stall;
    if (lat == 0) begin
      e.err = 1'b1;
      e.acc = m_acc[g];
      e.lat = 2 + TIMEOUT;
    end else begin
      base  = clr[g] ? 0 : m_acc[g];
      exact = base + longint'(w * x);
      m_acc[g] = wrap(exact);
      if (clr[g]) m_ovf[g] = 1'b0;
      if (exact > (longint'(1) << (ACC_W-1)) - 1 || exact < -(longint'(1) << (ACC_W-1)))
        m_ovf[g] = 1'b1;
      e.err = 1'b0;
      e.acc = m_acc[g];
      e.lat = 3 + lat;
    end
    e.ovf = m_ovf;
    m_pri = 1 - g;
    if (expect_resp) begin
      sb.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (n_done < n_pushed && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (n_done < n_pushed) chk("drain_timeout", 0, 1);
  endtask

  // Behavioural multiplier: answers lat cycles after the start pulse.
  initial begin
    logic signed [WIDTH-1:0] cw;
    logic signed [WIDTH-1:0] cx;
    int n;
    mul_done = 1'b0;
    mul_p = '0;
    forever begin
      @(negedge clk);
      if (!rst && mul_start) begin
        cw = mul_w;
        cx = mul_x;
        if (lat_q.size() == 0) begin
          chk("unexpected_mul_start", 1, 0);
          n = 0;
        end else begin
          n = lat_q.pop_front();
        end
        @(posedge clk);
        #1;
        chk("mul_start_one_cycle", longint'(mul_start), 0);
        if (n > 0) begin
          for (int k = 1; k < n; k++) begin
            @(negedge clk);
            chk("mul_operands_stable", longint'({mul_w, mul_x}), longint'({cw, cx}));
            @(posedge clk);
            #1;
          end
          mul_done = 1'b1;
          mul_p = cw * cx;
          @(posedge clk);
          #1;
          mul_done = 1'b0;
          mul_p = $urandom();
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t             e;
    int               stall;
    logic [ACC_W+1:0] snap;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        stall = 0;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          stall = e.stall;
          chk("resp_id", longint'(resp_id), e.id);
          chk("resp_acc", longint'($signed(resp_acc)), e.acc);
          chk("resp_err", longint'(resp_err), longint'(e.err));
          chk("acc_ovf", longint'(acc_ovf), longint'(e.ovf));
          chk("resp_latency", cyc - e.hs, e.lat);
        end
        snap = {resp_id, resp_err, resp_acc};
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          chk("resp_held_stable", longint'({resp_valid, resp_id, resp_err, resp_acc}),
              longint'({1'b1, snap}));
          chk("req_ready_during_resp", longint'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (stall >= 0 && e.hs >= 0) n_done++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    logic [1:0] c;
    int         l;
    rst = 1'b1;
    req_valid = 2'b00;
    req_w0 = '0; req_x0 = '0; req_w1 = '0; req_x1 = '0;
    req_clr = 2'b00;
    m_acc[0] = 0; m_acc[1] = 0; m_ovf = 2'b00; m_pri = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", all_outputs(), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(2'b01, 3, 4, 9, 9, 2'b01, 5, 0, 1);
    do_op(2'b01, -5, 7, 9, 9, 2'b00, 1, 1, 1);
    do_op(2'b10, 1, 1, 2, 2, 2'b10, 3, 0, 1);
    wait_drain();
    @(negedge clk);
    mul_done = 1'b1;
    mul_p = 16'h7FFF;
    @(negedge clk);
    mul_done = 1'b0;
    do_op(2'b01, 1, 0, 0, 0, 2'b00, 2, 0, 1);

    for (int i = 0; i < 4; i++)
      do_op(2'b11, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            2'b00, $urandom_range(1, 4), $urandom_range(0, 2), 1);

    do_op(2'b10, 0, 0, 2, 3, 2'b10, 0, 0, 1);
    do_op(2'b10, 0, 0, 1, 1, 2'b00, TIMEOUT, 0, 1);

    do_op(2'b01, 127, 127, 0, 0, 2'b01, 1, 0, 1);
    do_op(2'b01, 127, 127, 0, 0, 2'b00, 2, 0, 1);
    do_op(2'b01, 127, 127, 0, 0, 2'b00, 1, 10, 1);
    do_op(2'b01, 1, 1, 0, 0, 2'b01, 1, 0, 1);
    do_op(2'b10, 0, 0, -128, -128, 2'b10, 1, 0, 1);
    do_op(2'b10, 0, 0, -128, -128, 2'b00, 1, 0, 1);

    wait_drain();
    do_op(2'b01, 5, 5, 0, 0, 2'b00, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_midop_outputs", all_outputs(), 0);
    @(negedge clk);
    rst = 1'b0;
    m_acc[0] = 0; m_acc[1] = 0; m_ovf = 2'b00; m_pri = 0;
    lat_q.delete();
    repeat (TIMEOUT + 8) @(negedge clk);
    do_op(2'b01, 2, 3, 0, 0, 2'b00, 1, 0, 1);
    do_op(2'b10, 0, 0, 4, -3, 2'b00, 2, 0, 1);

    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      c = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      do_op(v, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            c, l, $urandom_range(0, 3), 1);
    end

    wait_drain();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
